// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the bit-serial adder
package serial_add_pkg;

    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit count needed to hold 0..width, so the counter never wraps.
    function automatic int CNT_W(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result bundle of the bit-serial adder
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/halfadder.sv
// rtl/halfadder.sv - vector half adder, bitwise sum and carry
module halfadder #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/serial_fa_slice.sv
// rtl/serial_fa_slice.sv - one-bit full adder from two half adders
module serial_fa_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    halfadder #(.WIDTH(1)) u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    halfadder #(.WIDTH(1)) u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    // At most one half adder can produce a carry, so OR equals majority.
    assign cout = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - sequences a shared full-adder slice over WIDTH cycles
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    serial_add_ctrl_if.slave  bus
);
    localparam int CW = CNT_W(WIDTH);

    generate
        if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("serial_add_ctrl: WIDTH out of range");
        end
    endgenerate

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_sr_nxt;
    logic             carry;
    logic [CW-1:0]    count;
    logic             accept;
    logic             last_bit;
    logic             slice_s;
    logic             slice_c;

    // New operands are taken only when idle or finishing; start during RUN is dropped.
    assign accept   = bus.start && (state == IDLE || state == DONE);
    assign last_bit = (state == RUN) && (count == CW'(WIDTH - 1));

    serial_fa_slice u_slice (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_c)
    );

    // Shift-based insert at the MSB keeps this valid down to WIDTH=1.
    assign sum_sr_nxt = (sum_sr >> 1) | (WIDTH'(slice_s) << (WIDTH - 1));

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shifters, carry, bit counter and result registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_a     <= '0;
            op_b     <= '0;
            sum_sr   <= '0;
            carry    <= 1'b0;
            count    <= '0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
        end else if (accept) begin
            op_a  <= bus.a;
            op_b  <= bus.b;
            carry <= 1'b0;
            count <= '0;
        end else if (state == RUN) begin
            sum_sr <= sum_sr_nxt;
            op_a   <= op_a >> 1;
            op_b   <= op_b >> 1;
            carry  <= slice_c;
            count  <= count + 1'b1;
            if (last_bit) begin
                bus.sum  <= sum_sr_nxt;
                bus.cout <= slice_c;
            end
        end
    end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition controller that sequences a 1-bit adder slice over WIDTH clock cycles. It accepts two WIDTH-bit operands on a start strobe and feeds one bit pair per cycle, LSB first, through a full-adder slice built from two `halfadder` instances. It keeps the carry in a register between cycles and assembles the sum in a shift register. It sits behind the multiplier's pin-level top as the partial-product accumulation engine, trading latency for a single shared adder bit.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.

- clk  in  1  rising-edge clock; all state changes on this edge.
- reset  in  1  reset, synchronous, active-low: state is cleared on a rising clk edge while reset=0.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  registered sum, LSB = bit 0.
- cout  out  1  registered final carry-out.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → load opA←a, opB←b, carry←0, count←0, go to RUN.
  - start=0 → stay in IDLE.
- RUN, each edge:
  - Slice computes s = opA[0]^opB[0]^carry and c = majority(opA[0], opB[0], carry).
  - sum_sr ← {s, sum_sr[WIDTH-1:1]}.
  - opA and opB shift right by 1.
  - carry ← c.
  - count ← count+1.
  - When count = WIDTH-1 on that edge, go to DONE and copy the final shift value to sum and c to cout.
- DONE: held for exactly one cycle, then:
  - start=1 → accept new operands and go to RUN (back-to-back).
  - start=0 → go to IDLE.
- start while in RUN is ignored; it is neither queued nor latched.
- a and b are don't-care except on the accepting edge.
- sum and cout hold their last result through IDLE and RUN until the next DONE updates them.
- Arithmetic is unsigned, modulo 2^WIDTH. cout is bit WIDTH of a+b.
- WIDTH=1: RUN lasts one edge, i.e. count = WIDTH-1 = 0 on the first RUN edge.
- Counter width is $clog2(WIDTH+1). The counter never wraps; it is reloaded to 0 on accept.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, state=IDLE, carry=0, count=0.
- Accept edge E0 (start=1 in IDLE/DONE). busy=1 from after E0 until after edge E(WIDTH).
- done=1 and the new sum/cout are visible in the cycle after edge E(WIDTH), i.e. latency is WIDTH+1 edges from start to done deasserting.
- Throughput is one addition per WIDTH+1 cycles when start is held high continuously.
- reset=0 mid-RUN:
  - The next edge returns to IDLE with all outputs at their reset values.
  - The partial result is discarded; no done pulse.
- reset=0 and start=1 on the same edge: reset wins.

## Structure
- Package `serial_add_pkg`:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding.
  - CNT_W function, $clog2(WIDTH+1).
  - WIDTH_MAX = 32 constant.
- Sub-module `serial_fa_slice` (combinational):
  - Inputs a, b, cin; outputs s, cout.
  - Two `halfadder` instances, WIDTH=1, with an OR of their carries.
  - The controller instantiates it once.
- The controller holds the FSM, counter, operand shift registers, carry flop and result registers only.

## Test plan
- WIDTH=8, reset low 2 cycles, then a=0x5A, b=0x3C, start pulse → busy for 8 cycles; done after 9 edges with sum=0x96, cout=0.
- WIDTH=8, a=0xFF, b=0x01 → sum=0x00, cout=1; then a=0xFF, b=0xFF → sum=0xFE, cout=1.
- WIDTH=8, start held high continuously with a=0x10, b=0x20 → done every 9 cycles, sum=0x30 each time, no missed or extra pulses. start re-pulsed at cycles 3–5 of RUN → ignored, single done.
- WIDTH=8, reset driven low at the 4th RUN cycle → next edge busy=0, done=0, sum=0x00, cout=0, no done pulse. A following add of 0x01+0x01 yields 0x02.
- WIDTH=1: the four combinations 0+0, 0+1, 1+0 and 1+1 → {cout,sum} = 00, 01, 01, 10, each with done 2 edges after accept.
- Randomised WIDTH=8 sweep of 1000 operand pairs against a+b reference; sum/cout stable between done pulses.
